// File: rtl/icache_pkg.sv
// Shared parameters and types for the instruction-cache fill controller.
package icache_pkg;

  localparam int unsigned TAG_W  = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned LINES  = 16;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StResp
  } state_e;

  // Flat word index into the data store.
  function automatic logic [IDX_W+OFF_W-1:0] word_sel(logic [IDX_W-1:0] idx,
                                                      logic [OFF_W-1:0] off);
    return {idx, off};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for a direct-mapped cache: one combinational read port,
// one word-write port, and a line-install strobe that sets valid and tag.
module icache_array
  import icache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              install_i,
  input  logic [TAG_W-1:0]  install_tag_i
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES*WORDS];

  always_comb begin
    valid_d = valid_q;
    if (install_i) valid_d[wr_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en_i)   data_q[word_sel(wr_idx_i, wr_off_i)] <= wr_data_i;
    if (install_i) tag_q[wr_idx_i] <= install_tag_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[word_sel(rd_idx_i, rd_off_i)];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction-side cache controller: serves hits in the request cycle and fills
// whole 4-word lines from backing memory on a miss.
module icache_fill_ctrl
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] DataIn,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0]  rd_idx;
  logic [OFF_W-1:0]  rd_off;
  logic              wr_en, install;
  logic              req_legal, hit;

  logic        done_c, stall_c, hit_c, err_c, mem_rd_c;
  logic [15:0] dout_c, mem_addr_c;

  logic unused_inputs;
  assign unused_inputs = ^{DataIn, createdump};

  // Idle looks up the incoming address; Fill/Resp look up the latched one.
  assign rd_idx = (state_q == StIdle) ? Addr[6:3] : addr_q[6:3];
  assign rd_off = (state_q == StIdle) ? Addr[2:1] : addr_q[2:1];

  assign req_legal = Rd & ~Wr & ~Addr[0];
  assign hit       = rd_valid & (rd_tag == Addr[15:7]);
  assign wr_en     = (state_q == StFill) & mem_valid;
  assign install   = wr_en & (cnt_q == 2'd3);

  icache_array u_array (
    .clk_i         (clk),
    .rst_i         (rst),
    .rd_idx_i      (rd_idx),
    .rd_off_i      (rd_off),
    .rd_valid_o    (rd_valid),
    .rd_tag_o      (rd_tag),
    .rd_data_o     (rd_data),
    .wr_en_i       (wr_en),
    .wr_idx_i      (addr_q[6:3]),
    .wr_off_i      (cnt_q),
    .wr_data_i     (mem_rdata),
    .install_i     (install),
    .install_tag_i (addr_q[15:7])
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_legal && !hit) begin
          addr_d  = Addr;
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (mem_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 2'd3) state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    done_c     = 1'b0;
    stall_c    = 1'b0;
    hit_c      = 1'b0;
    err_c      = 1'b0;
    mem_rd_c   = 1'b0;
    dout_c     = '0;
    mem_addr_c = '0;
    unique case (state_q)
      StIdle: begin
        err_c = Wr | (Rd & Addr[0]);
        if (req_legal) begin
          if (hit) begin
            done_c = 1'b1;
            hit_c  = 1'b1;
            dout_c = rd_data;
          end else begin
            stall_c = 1'b1;
          end
        end
      end
      StFill: begin
        stall_c    = 1'b1;
        mem_rd_c   = 1'b1;
        mem_addr_c = {addr_q[15:3], cnt_q, 1'b0};
      end
      StResp: begin
        dout_c = rd_data;
        done_c = Rd & (Addr == addr_q);
      end
      default: ;
    endcase
  end

  // Outputs are forced quiet for as long as reset is held.
  assign Done     = ~rst & done_c;
  assign Stall    = ~rst & stall_c;
  assign CacheHit = ~rst & hit_c;
  assign err      = ~rst & err_c;
  assign mem_rd   = ~rst & mem_rd_c;
  assign DataOut  = rst ? '0 : dout_c;
  assign mem_addr = rst ? '0 : mem_addr_c;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl with a line-level cache model and a
// variable-latency backing memory.
module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = '0, DataIn = '0, DataOut, mem_addr, mem_rdata;
  logic        Rd = 1'b0, Wr = 1'b0, createdump = 1'b0;
  logic        Done, Stall, CacheHit, err, mem_rd, mem_valid;

  int total = 0;
  int bad   = 0;
  int unsigned mem_lat = 2;
  int unsigned lat_cnt;
  logic [15:0] hs_q[$];

  bit          mvalid[16];
  logic [8:0]  mtag[16];

  icache_fill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .Rd         (Rd),
    .Wr         (Wr),
    .DataIn     (DataIn),
    .createdump (createdump),
    .DataOut    (DataOut),
    .Done       (Done),
    .Stall      (Stall),
    .CacheHit   (CacheHit),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A3C;
  endfunction

  // Backing memory: answers mem_latency cycles after it first sees mem_rd.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt   <= 0;
      mem_valid <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_valid <= 1'b0;
      if (mem_rd && !mem_valid) begin
        if (lat_cnt + 1 >= mem_lat) begin
          mem_valid <= 1'b1;
          mem_rdata <= mem_fn(mem_addr);
          lat_cnt   <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else begin
        lat_cnt <= 0;
      end
    end
  end

  always @(posedge clk) if (!rst && mem_rd && mem_valid) hs_q.push_back(mem_addr);

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic run_read(input logic [15:0] a);
    bit          exp_hit;
    int          n;
    bit          overlap;
    logic [15:0] ea;
    exp_hit = mvalid[a[6:3]] && (mtag[a[6:3]] == a[15:7]);
    @(posedge clk); #1;
    Rd = 1'b1; Wr = 1'b0; Addr = a;
    hs_q.delete();
    @(negedge clk);
    if (exp_hit) begin
      total++;
      if (Done !== 1'b1 || CacheHit !== 1'b1 || Stall !== 1'b0 || mem_rd !== 1'b0 ||
          DataOut !== mem_fn(a)) begin
        bad++;
        $display("FAIL hit a=%h: Done=%b CacheHit=%b Stall=%b mem_rd=%b DataOut=%h, want 1 1 0 0 %h",
                 a, Done, CacheHit, Stall, mem_rd, DataOut, mem_fn(a));
      end
    end else begin
      total++;
      if (Stall !== 1'b1 || Done !== 1'b0 || CacheHit !== 1'b0) begin
        bad++;
        $display("FAIL miss_stall a=%h: Stall=%b Done=%b CacheHit=%b, want 1 0 0",
                 a, Stall, Done, CacheHit);
      end
      n = 0;
      overlap = 1'b0;
      while (Stall === 1'b1 && n < 60) begin
        if (Done === 1'b1) overlap = 1'b1;
        @(negedge clk);
        n++;
      end
      total++;
      if (overlap || n >= 60) begin
        bad++;
        $display("FAIL fill_wait a=%h: cycles=%0d done_with_stall=%b, want <60 and 0",
                 a, n, overlap);
      end
      total++;
      if (Done !== 1'b1 || CacheHit !== 1'b0 || Stall !== 1'b0 || DataOut !== mem_fn(a)) begin
        bad++;
        $display("FAIL resp a=%h: Done=%b CacheHit=%b Stall=%b DataOut=%h, want 1 0 0 %h",
                 a, Done, CacheHit, Stall, DataOut, mem_fn(a));
      end
      total++;
      if (hs_q.size() != 4) begin
        bad++;
        $display("FAIL fill_len a=%h: words=%0d, want 4", a, hs_q.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          ea = {a[15:3], 3'b000} + 16'(2 * i);
          total++;
          if (hs_q[i] !== ea) begin
            bad++;
            $display("FAIL fill_addr a=%h word %0d: mem_addr=%h, want %h", a, i, hs_q[i], ea);
          end
        end
      end
      mvalid[a[6:3]] = 1'b1;
      mtag[a[6:3]]   = a[15:7];
    end
  endtask

  task automatic test_idle();
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0; Addr = 16'($urandom);
    @(negedge clk);
    total++;
    if (Done !== 1'b0 || Stall !== 1'b0 || CacheHit !== 1'b0 || mem_rd !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL idle: Done=%b Stall=%b CacheHit=%b mem_rd=%b err=%b, want all 0",
               Done, Stall, CacheHit, mem_rd, err);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    Rd = 1'b1; Wr = 1'b1; Addr = 16'h0003;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (Done !== 1'b0 || Stall !== 1'b0 || CacheHit !== 1'b0 || err !== 1'b0 ||
        mem_rd !== 1'b0 || DataOut !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: Done=%b Stall=%b CacheHit=%b err=%b mem_rd=%b DataOut=%h, want 0",
               Done, Stall, CacheHit, err, mem_rd, DataOut);
    end
    Rd = 1'b0; Wr = 1'b0; Addr = '0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    test_idle();
  endtask

  task automatic test_directed();
    mem_lat = 2;
    run_read(16'h0000);
    run_read(16'h0004);
    run_read(16'h0086);
    run_read(16'h0000);
    test_idle();
  endtask

  task automatic test_err();
    logic        rd_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        wr_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] ad_t [4] = '{16'h0003, 16'h0004, 16'h0000, 16'h0001};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      Rd = rd_t[i]; Wr = wr_t[i]; Addr = ad_t[i];
      @(negedge clk);
      total++;
      if (err !== 1'b1 || Done !== 1'b0 || Stall !== 1'b0 || mem_rd !== 1'b0 || CacheHit !== 1'b0) begin
        bad++;
        $display("FAIL err case %0d: err=%b Done=%b Stall=%b mem_rd=%b CacheHit=%b, want 1 0 0 0 0",
                 i, err, Done, Stall, mem_rd, CacheHit);
      end
    end
    test_idle();
    run_read(16'h0004);
  endtask

  task automatic test_abandon();
    int n;
    mem_lat = 2;
    @(posedge clk); #1;
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0100;
    hs_q.delete();
    n = 0;
    while (hs_q.size() < 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    Rd = 1'b0; Addr = 16'($urandom);
    @(negedge clk);
    while (Stall === 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 80 || Done !== 1'b0 || CacheHit !== 1'b0) begin
      bad++;
      $display("FAIL abandon_resp: cycles=%0d Done=%b CacheHit=%b, want <80 0 0", n, Done, CacheHit);
    end
    total++;
    if (hs_q.size() != 4) begin
      bad++;
      $display("FAIL abandon_fill_len: words=%0d, want 4", hs_q.size());
    end
    mvalid[0] = 1'b1;
    mtag[0]   = 9'd2;
    run_read(16'h0102);
  endtask

  task automatic test_reset_mid_fill();
    int n;
    mem_lat = 2;
    @(posedge clk); #1;
    Rd = 1'b1; Wr = 1'b0; Addr = 16'h0200;
    hs_q.delete();
    n = 0;
    while (hs_q.size() < 1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (n >= 40 || Done !== 1'b0 || Stall !== 1'b0 || CacheHit !== 1'b0 || err !== 1'b0 ||
        mem_rd !== 1'b0 || DataOut !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_fill: n=%0d Done=%b Stall=%b CacheHit=%b err=%b mem_rd=%b DataOut=%h, want 0",
               n, Done, Stall, CacheHit, err, mem_rd, DataOut);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    Rd = 1'b0;
    test_idle();
    run_read(16'h0200);
  endtask

  task automatic test_random();
    logic [8:0]  tg;
    logic [3:0]  ix;
    logic [1:0]  of;
    logic [15:0] a;
    for (int it = 0; it < 80; it++) begin
      mem_lat = $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
        Rd = 1'b1; Wr = 1'($urandom); Addr = 16'($urandom) | 16'h0001;
        @(negedge clk);
        total++;
        if (err !== 1'b1 || Done !== 1'b0 || Stall !== 1'b0 || mem_rd !== 1'b0) begin
          bad++;
          $display("FAIL rand_err a=%h: err=%b Done=%b Stall=%b mem_rd=%b, want 1 0 0 0",
                   Addr, err, Done, Stall, mem_rd);
        end
      end else begin
        tg = 9'($urandom_range(0, 2));
        ix = 4'($urandom_range(0, 3));
        of = 2'($urandom);
        a  = {tg, ix, of, 1'b0};
        run_read(a);
      end
      if ($urandom_range(0, 3) == 0) test_idle();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_directed();
    test_err();
    test_abandon();
    test_reset_mid_fill();
    test_random();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
